// File: rtl/sigmoid_result_serializer.sv
// Buffers clamped Q8.8 sigmoid results in a small FIFO and streams each word
// out as two bytes, high byte first, over a byte-wide valid/ready port.
module sigmoid_result_serializer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     clamp_seen,
    input  logic                     clear_flags
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];
    localparam logic [15:0] ONE_Q88 = 16'h0100;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HI   = 2'd1;
    localparam logic [1:0] LO   = 2'd2;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [15:0]   hold_q, hold_d;
    logic          clamp_seen_q, clamp_seen_d;

    logic          push;
    logic          pop;
    logic          over_range;
    logic          not_empty;
    logic [15:0]   wr_data;

    // in_ready comes from the registered count only; a same-cycle pop never
    // opens a slot early.
    assign in_ready   = ~rst & (count_q != FULL_LEVEL);
    assign not_empty  = (count_q != '0);
    assign push       = in_valid & in_ready;
    assign over_range = (in_data > ONE_Q88);
    assign wr_data    = over_range ? ONE_Q88 : in_data;

    // The head is refilled either from IDLE or at the end of the low byte,
    // so consecutive words stream without a bubble.
    assign pop = not_empty & ((state_q == IDLE) | ((state_q == LO) & out_ready));

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (not_empty) begin
                    state_d = HI;
                end
            end
            HI: begin
                if (out_ready) begin
                    state_d = LO;
                end
            end
            LO: begin
                if (out_ready) begin
                    state_d = not_empty ? HI : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            hold_d = mem[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    // A clamp in the same cycle as clear_flags keeps the flag set.
    always_comb begin
        clamp_seen_d = clamp_seen_q;
        if (push && over_range) begin
            clamp_seen_d = 1'b1;
        end else if (clear_flags) begin
            clamp_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            hold_q       <= '0;
            clamp_seen_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            hold_q       <= hold_d;
            clamp_seen_q <= clamp_seen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        out_data = 8'h00;
        case (state_q)
            HI:      out_data = hold_q[15:8];
            LO:      out_data = hold_q[7:0];
            default: out_data = 8'h00;
        endcase
    end

    assign out_valid  = (state_q == HI) | (state_q == LO);
    assign out_last   = (state_q == LO);
    assign level      = count_q;
    assign clamp_seen = clamp_seen_q;

endmodule

// File: tb/tb_sigmoid_result_serializer.sv
// Scoreboard bench: the driver queues the expected byte stream for every
// accepted word, an independent monitor pops and compares each output byte.
module tb_sigmoid_result_serializer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [LW-1:0] level;
    logic          clamp_seen;
    logic          clear_flags;

    sigmoid_result_serializer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .level       (level),
        .clamp_seen  (clamp_seen),
        .clear_flags (clear_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [8:0] exp_q[$];

    bit   rand_ready = 0;
    bit   stream_mode = 0;
    int   cyc = 0;
    int   stream_cnt = 0;
    int   stream_first = -1;
    int   stream_last = -1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Reference: word saturates at 1.0 (0x0100), then splits high byte first.
    function automatic void expect_word(input logic [15:0] d);
        logic [15:0] v;
        v = (d > 16'h0100) ? 16'h0100 : d;
        exp_q.push_back({1'b0, v[15:8]});
        exp_q.push_back({1'b1, v[7:0]});
    endfunction

    // Monitor
    bit         prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;
    always @(negedge clk) begin
        logic [8:0] e;
        cyc++;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk(out_valid && out_data == prev_data && out_last == prev_last,
                    "stall_stable", {out_valid, out_last, out_data},
                    {1'b1, prev_last, prev_data});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_byte", {out_last, out_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({out_last, out_data} == e, "byte", {out_last, out_data}, e);
                end
                if (stream_mode) begin
                    if (stream_first < 0) stream_first = cyc;
                    stream_last = cyc;
                    stream_cnt++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic push_word(input logic [15:0] d, input logic clr);
        bit acc = 0;
        in_data     = d;
        in_valid    = 1'b1;
        clear_flags = clr;
        for (int n = 0; n < 500 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) acc = 1;
        end
        if (acc) begin
            expect_word(d);
            @(posedge clk);
            #1;
        end else begin
            chk(0, "push_timeout", 0, 1);
        end
        in_valid    = 1'b0;
        clear_flags = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(exp_q.size() == 0 && !out_valid, "drain", exp_q.size(), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_cnt;
        rst         = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        clear_flags = 1'b0;
        #1;
        chk(in_ready == 1'b0, "ready_in_reset", in_ready, 0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk(!out_valid && !out_last, "rst_out_valid_last", {out_valid, out_last}, 0);
        chk(out_data == 8'h00, "rst_out_data", out_data, 8'h00);
        chk(level == 0, "rst_level", level, 0);
        chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
        chk(clamp_seen == 1'b0, "rst_clamp_seen", clamp_seen, 0);

        // Single word and latency
        out_ready = 1'b1;
        tick();
        push_word(16'h00C3, 1'b0);
        chk(out_valid == 1'b0, "lat_push_edge", out_valid, 0);
        tick();
        chk(out_valid == 1'b1 && out_data == 8'h00 && !out_last, "lat_hi_byte",
            {out_valid, out_last, out_data}, {2'b10, 8'h00});
        chk(clamp_seen == 1'b0, "single_clamp", clamp_seen, 0);
        drain();

        // Clamp flag behaviour
        push_word(16'h0180, 1'b0);
        chk(clamp_seen == 1'b1, "clamp_set", clamp_seen, 1);
        drain();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk(clamp_seen == 1'b0, "clamp_clear", clamp_seen, 0);
        push_word(16'h0100, 1'b0);
        chk(clamp_seen == 1'b0, "no_clamp_at_one", clamp_seen, 0);
        drain();
        push_word(16'h0200, 1'b1);
        chk(clamp_seen == 1'b1, "clamp_beats_clear", clamp_seen, 1);
        drain();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;

        // Backpressure until full
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            in_data  = 16'(i * 16);
            in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) break;
            expect_word(16'(i * 16));
            acc_cnt++;
            tick();
        end
        in_valid = 1'b0;
        chk(acc_cnt == DEPTH + 1, "full_accepted", acc_cnt, DEPTH + 1);
        chk(level == DEPTH, "full_level", level, DEPTH);
        chk(out_valid && out_data == 8'h00 && !out_last, "full_head",
            {out_valid, out_last, out_data}, {2'b10, 8'h00});
        tick();
        out_ready = 1'b1;
        drain();

        // Streaming with continuous output
        stream_mode = 1;
        for (int i = 0; i < 16; i++) begin
            push_word(16'($urandom_range(0, 16'h0100)), 1'b0);
        end
        drain();
        stream_mode = 0;
        chk(stream_cnt == 32, "stream_bytes", stream_cnt, 32);
        chk(stream_last - stream_first == 31, "stream_gapless",
            stream_last - stream_first, 31);

        // Random stalls and random input gaps
        rand_ready = 1;
        for (int i = 0; i < 200; i++) begin
            while ($urandom_range(0, 1) == 1) tick();
            push_word(16'($urandom_range(0, 16'h01FF)), 1'b0);
        end
        drain();
        rand_ready = 0;
        tick();

        // Reset while the low byte is pending
        out_ready = 1'b0;
        push_word(16'h0080, 1'b0);
        for (int n = 0; n < 20 && !out_valid; n++) tick();
        chk(out_valid && out_data == 8'h00, "pre_rst_hi", {out_valid, out_data},
            {1'b1, 8'h00});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk(out_last == 1'b1 && out_data == 8'h80, "pre_rst_lo",
            {out_last, out_data}, {1'b1, 8'h80});
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk(out_valid == 1'b0, "rst_async_valid", out_valid, 0);
        chk(level == 0, "rst_async_level", level, 0);
        tick();
        rst = 1'b0;
        #1;
        chk(in_ready == 1'b1, "rst_release_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk(out_valid == 1'b0, "no_trailing_byte", out_valid, 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
